pe_ec_scheduler: RTL and testbench

//  Sequencer for one PE_EC encoder processing element (binary conv + max-pool + norm/pindex).
//  Per layer: one weight/norm_ref load handshake, then a raster walk of pooled output positions.
//  Per position: issue a window read to the input buffer, strobe PE_EC, hand the result to the

---
 rtl/pe_ec_scheduler.sv | 131 +++++++++++++
 tb/tb_pe_ec_scheduler.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_ec_scheduler.sv
// Control sequencer for one PE_EC encoder element: weight load handshake, then a raster
// walk of pooled output positions (window read, PE strobe, valid/ready handoff to writeback).
module pe_ec_scheduler #(
    parameter int POOL_H   = 2,
    parameter int POOL_W   = 2,
    parameter int STRIDE_H = 1,
    parameter int STRIDE_W = 1,
    parameter int OUT_H    = 8,
    parameter int OUT_W    = 8,
    parameter int ADDR_W   = 8,
    parameter int RD_LAT   = 1,
    parameter int PE_LAT   = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_wgt_req,
    input  logic              i_wgt_ack,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_row,
    output logic [ADDR_W-1:0] o_rd_col,
    output logic              o_pe_in_en,
    output logic              o_pe_s,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ADDR_W-1:0] o_out_row,
    output logic [ADDR_W-1:0] o_out_col
);

    localparam int WAIT_W = 16;
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(POOL_H * STRIDE_H);
    localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(POOL_W * STRIDE_W);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(OUT_H - 1);
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(OUT_W - 1);
    localparam logic [WAIT_W-1:0] RD_WAIT  = WAIT_W'(RD_LAT);
    localparam logic [WAIT_W-1:0] PE_WAIT  = WAIT_W'(PE_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADW,
        S_FETCH,
        S_COMPUTE,
        S_EMIT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_row;
    logic [ADDR_W-1:0] r_col;
    logic [WAIT_W-1:0] r_wait;
    logic              w_transfer;
    logic              w_last;

    assign w_transfer = (r_state == S_EMIT) && i_out_ready;
    assign w_last     = (r_row == LAST_ROW) && (r_col == LAST_COL);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort overrides every transition; in IDLE it simply keeps the FSM idle.
    always_comb begin
        w_next = r_state;
        if (i_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (i_start)            w_next = S_LOADW;
                S_LOADW:   if (i_wgt_ack)          w_next = S_FETCH;
                S_FETCH:   if (r_wait == RD_WAIT)  w_next = S_COMPUTE;
                S_COMPUTE: if (r_wait == PE_WAIT)  w_next = S_EMIT;
                S_EMIT:    if (i_out_ready)        w_next = w_last ? S_DONE : S_FETCH;
                S_DONE:                            w_next = S_IDLE;
                default:                           w_next = S_IDLE;
            endcase
        end
    end

    // r_wait counts cycles spent in FETCH/COMPUTE; zero marks the strobe cycle of each.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wait <= '0;
            r_row  <= '0;
            r_col  <= '0;
        end else begin
            if (w_next != r_state) begin
                r_wait <= '0;
            end else if ((r_state == S_FETCH) || (r_state == S_COMPUTE)) begin
                r_wait <= r_wait + 1'b1;
            end

            if (i_abort || (r_state == S_IDLE)) begin
                r_row <= '0;
                r_col <= '0;
            end else if (w_transfer) begin
                if (w_last) begin
                    r_row <= '0;
                    r_col <= '0;
                end else if (r_col == LAST_COL) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_busy      = (r_state != S_IDLE);
        o_pe_s      = (r_state != S_IDLE);
        o_done      = (r_state == S_DONE);
        o_wgt_req   = (r_state == S_LOADW);
        o_rd_en     = (r_state == S_FETCH) && (r_wait == '0);
        o_pe_in_en  = (r_state == S_COMPUTE) && (r_wait == '0);
        o_out_valid = (r_state == S_EMIT);
        o_rd_row    = r_row * ROW_STEP;
        o_rd_col    = r_col * COL_STEP;
        o_out_row   = r_row;
        o_out_col   = r_col;
    end

endmodule

// File: tb/tb_pe_ec_scheduler.sv
// Self-checking bench for pe_ec_scheduler: logs protocol events and compares them against
// position order and phase timing derived directly from the layer parameters.
module tb_pe_ec_scheduler;

    localparam int POOL_H   = 2;
    localparam int POOL_W   = 2;
    localparam int STRIDE_H = 1;
    localparam int STRIDE_W = 2;
    localparam int OUT_H    = 2;
    localparam int OUT_W    = 3;
    localparam int ADDR_W   = 8;
    localparam int RD_LAT   = 1;
    localparam int PE_LAT   = 1;
    localparam int NPOS     = OUT_H * OUT_W;
    localparam int ROW_STEP = POOL_H * STRIDE_H;
    localparam int COL_STEP = POOL_W * STRIDE_W;
    localparam int RD_LAT2  = 2;
    localparam int PE_LAT2  = 0;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic              wgtAck;
    logic              outReady;
    logic              busy, done, wgtReq, rdEn, peInEn, peS, outValid;
    logic [ADDR_W-1:0] rdRow, rdCol, outRow, outCol;
    logic              busy2, done2, wgtReq2, rdEn2, peInEn2, peS2, outValid2;
    logic [ADDR_W-1:0] rdRow2, rdCol2, outRow2, outCol2;

    wire [6:0]          ctrlVec = {busy, done, wgtReq, rdEn, peInEn, peS, outValid};
    wire [4*ADDR_W-1:0] addrVec = {rdRow, rdCol, outRow, outCol};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int rdCycQ[$], rdRowQ[$], rdColQ[$], peCycQ[$];
    int xCycQ[$], xRowQ[$], xColQ[$], xFirstQ[$], xValidQ[$], doneCycQ[$];
    int rd2Q[$], pe2Q[$], done2Q[$];
    int wgtCycles, wgtLast;
    bit inValid = 0;
    bit prevXfer = 0;
    int firstV, vRow, vCol, vCnt;

    int ackDelay  = 0;
    int readyMode = 0;
    int reqCnt    = 0;
    int stallLeft = 0;
    bit stallUsed = 0;

    pe_ec_scheduler #(
        .POOL_H(POOL_H), .POOL_W(POOL_W), .STRIDE_H(STRIDE_H), .STRIDE_W(STRIDE_W),
        .OUT_H(OUT_H), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .PE_LAT(PE_LAT)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .o_busy(busy), .o_done(done), .o_wgt_req(wgtReq), .i_wgt_ack(wgtAck),
        .o_rd_en(rdEn), .o_rd_row(rdRow), .o_rd_col(rdCol),
        .o_pe_in_en(peInEn), .o_pe_s(peS), .o_out_valid(outValid), .i_out_ready(outReady),
        .o_out_row(outRow), .o_out_col(outCol)
    );

    // Single-position instance with different latencies, shares all stimulus.
    pe_ec_scheduler #(
        .POOL_H(POOL_H), .POOL_W(POOL_W), .STRIDE_H(STRIDE_H), .STRIDE_W(STRIDE_W),
        .OUT_H(1), .OUT_W(1), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT2), .PE_LAT(PE_LAT2)
    ) dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .o_busy(busy2), .o_done(done2), .o_wgt_req(wgtReq2), .i_wgt_ack(wgtAck),
        .o_rd_en(rdEn2), .o_rd_row(rdRow2), .o_rd_col(rdCol2),
        .o_pe_in_en(peInEn2), .o_pe_s(peS2), .o_out_valid(outValid2), .i_out_ready(outReady),
        .o_out_row(outRow2), .o_out_col(outCol2)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Weight-ack responder and writeback ready pattern, updated just after each rising edge.
    initial begin
        wgtAck   = 0;
        outReady = 0;
        forever begin
            @(posedge clk);
            #1;
            if (wgtReq) begin
                reqCnt++;
                wgtAck = (reqCnt > ackDelay);
            end else begin
                reqCnt = 0;
                wgtAck = 0;
            end
            case (readyMode)
                0: outReady = 1;
                1: outReady = ($urandom_range(0, 3) != 0);
                default: begin
                    if (outValid && outRow == 0 && outCol == 1 && !stallUsed) begin
                        if (stallLeft < 4) begin
                            outReady = 0;
                            stallLeft++;
                        end else begin
                            outReady  = 1;
                            stallUsed = 1;
                        end
                    end else begin
                        outReady = 1;
                    end
                end
            endcase
        end
    end

    // Event logger on the falling edge, plus invariants that hold every cycle.
    always @(negedge clk) begin
        checks++;
        if (peS !== busy) begin
            errors++;
            $display("[TB] FAIL pe_s_tracks_busy: pe_s=%b busy=%b cycle %0d", peS, busy, cyc);
        end
        if (prevXfer) begin
            checks++;
            if (outValid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL valid_drop_after_xfer: out_valid=%b want 0 cycle %0d", outValid, cyc);
            end
        end
        prevXfer = outValid && outReady;
        if (rdEn) begin
            rdCycQ.push_back(cyc);
            rdRowQ.push_back(int'(rdRow));
            rdColQ.push_back(int'(rdCol));
        end
        if (peInEn) peCycQ.push_back(cyc);
        if (wgtReq) begin
            wgtCycles++;
            wgtLast = cyc;
        end
        if (outValid) begin
            if (!inValid) begin
                inValid = 1;
                firstV  = cyc;
                vRow    = int'(outRow);
                vCol    = int'(outCol);
                vCnt    = 0;
            end else begin
                checks++;
                if (int'(outRow) != vRow || int'(outCol) != vCol) begin
                    errors++;
                    $display("[TB] FAIL hold_stable: out=(%0d,%0d) want (%0d,%0d) cycle %0d",
                             outRow, outCol, vRow, vCol, cyc);
                end
            end
            vCnt++;
            if (outReady) begin
                xCycQ.push_back(cyc);
                xRowQ.push_back(vRow);
                xColQ.push_back(vCol);
                xFirstQ.push_back(firstV);
                xValidQ.push_back(vCnt);
                inValid = 0;
            end
        end else begin
            inValid = 0;
        end
        if (done) begin
            doneCycQ.push_back(cyc);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL done_busy: busy=%b want 1 during done cycle %0d", busy, cyc);
            end
        end
        if (rdEn2)   rd2Q.push_back(cyc);
        if (peInEn2) pe2Q.push_back(cyc);
        if (done2)   done2Q.push_back(cyc);
    end

    task automatic clear_logs();
        rdCycQ.delete(); rdRowQ.delete(); rdColQ.delete(); peCycQ.delete();
        xCycQ.delete(); xRowQ.delete(); xColQ.delete(); xFirstQ.delete(); xValidQ.delete();
        doneCycQ.delete(); rd2Q.delete(); pe2Q.delete(); done2Q.delete();
        wgtCycles = 0;
        wgtLast   = 0;
    endtask

    task automatic run_layer(input int ackD, input int rMode, input bit noise);
        bit ok;
        ackDelay  = ackD;
        readyMode = rMode;
        @(posedge clk);
        #1;
        clear_logs();
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                ok = 1;
                break;
            end
            if (noise) start = ($urandom_range(0, 1) == 1);
            @(posedge clk);
            #1;
        end
        start = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL layer_timeout: done=%b, want a done pulse within 3000 cycles", done);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_done: busy=%b want 0", busy);
        end
    endtask

    task automatic check_layer(input int ackD);
        int r, c;
        checks++;
        if (wgtCycles != ackD + 1) begin
            errors++;
            $display("[TB] FAIL wgt_req_len: %0d cycles want %0d", wgtCycles, ackD + 1);
        end
        checks++;
        if (rdCycQ.size() != NPOS || peCycQ.size() != NPOS || xCycQ.size() != NPOS
            || doneCycQ.size() != 1) begin
            errors++;
            $display("[TB] FAIL event_counts: rd=%0d pe=%0d xfer=%0d done=%0d want %0d/%0d/%0d/1",
                     rdCycQ.size(), peCycQ.size(), xCycQ.size(), doneCycQ.size(), NPOS, NPOS, NPOS);
            return;
        end
        for (int k = 0; k < NPOS; k++) begin
            r = k / OUT_W;
            c = k % OUT_W;
            checks++;
            if (rdRowQ[k] != r * ROW_STEP || rdColQ[k] != c * COL_STEP) begin
                errors++;
                $display("[TB] FAIL rd_addr[%0d]: (%0d,%0d) want (%0d,%0d)",
                         k, rdRowQ[k], rdColQ[k], r * ROW_STEP, c * COL_STEP);
            end
            checks++;
            if (xRowQ[k] != r || xColQ[k] != c) begin
                errors++;
                $display("[TB] FAIL out_pos[%0d]: (%0d,%0d) want (%0d,%0d)", k, xRowQ[k], xColQ[k], r, c);
            end
            checks++;
            if (peCycQ[k] - rdCycQ[k] != 1 + RD_LAT) begin
                errors++;
                $display("[TB] FAIL rd_to_pe[%0d]: %0d want %0d", k, peCycQ[k] - rdCycQ[k], 1 + RD_LAT);
            end
            checks++;
            if (xFirstQ[k] - peCycQ[k] != 1 + PE_LAT) begin
                errors++;
                $display("[TB] FAIL pe_to_valid[%0d]: %0d want %0d", k, xFirstQ[k] - peCycQ[k], 1 + PE_LAT);
            end
            checks++;
            if (k == 0) begin
                if (rdCycQ[0] - wgtLast != 1) begin
                    errors++;
                    $display("[TB] FAIL ack_to_rd: %0d want 1", rdCycQ[0] - wgtLast);
                end
            end else if (rdCycQ[k] - xCycQ[k-1] != 1) begin
                errors++;
                $display("[TB] FAIL xfer_to_rd[%0d]: %0d want 1", k, rdCycQ[k] - xCycQ[k-1]);
            end
        end
        checks++;
        if (doneCycQ[0] - xCycQ[NPOS-1] != 1) begin
            errors++;
            $display("[TB] FAIL last_to_done: %0d want 1", doneCycQ[0] - xCycQ[NPOS-1]);
        end
    endtask

    task automatic test_reset();
        rst   = 1;
        start = 0;
        abort = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (ctrlVec !== '0 || addrVec !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: ctrl=%b addr=%h want 0", ctrlVec, addrVec);
        end
        @(posedge clk);
        #1;
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ctrlVec !== '0 || addrVec !== '0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: ctrl=%b addr=%h want 0", ctrlVec, addrVec);
        end
    endtask

    task automatic test_layer_basic();
        run_layer(3, 0, 0);
        check_layer(3);
        checks++;
        if (rdCycQ.size() >= 2 && rdCycQ[1] - rdCycQ[0] != 1 + RD_LAT + 1 + PE_LAT + 1) begin
            errors++;
            $display("[TB] FAIL rd_spacing: %0d want %0d", rdCycQ[1] - rdCycQ[0], 3 + RD_LAT + PE_LAT);
        end
        checks++;
        if (rd2Q.size() != 1 || pe2Q.size() != 1 || done2Q.size() != 1) begin
            errors++;
            $display("[TB] FAIL single_pos_counts: rd=%0d pe=%0d done=%0d want 1/1/1",
                     rd2Q.size(), pe2Q.size(), done2Q.size());
        end else begin
            checks++;
            if (rd2Q[0] - wgtLast != 1 || pe2Q[0] - rd2Q[0] != 1 + RD_LAT2
                || done2Q[0] - pe2Q[0] != 1 + PE_LAT2 + 1) begin
                errors++;
                $display("[TB] FAIL single_pos_timing: ack->rd %0d rd->pe %0d pe->done %0d want 1/%0d/%0d",
                         rd2Q[0] - wgtLast, pe2Q[0] - rd2Q[0], done2Q[0] - pe2Q[0],
                         1 + RD_LAT2, 2 + PE_LAT2);
            end
        end
    endtask

    task automatic test_backpressure();
        stallLeft = 0;
        stallUsed = 0;
        run_layer(1, 2, 0);
        check_layer(1);
        checks++;
        if (xValidQ.size() < 2 || xValidQ[1] != 5 || xColQ[1] != 1) begin
            errors++;
            $display("[TB] FAIL stall_hold: valid cycles at (0,1)=%0d want 5",
                     (xValidQ.size() >= 2) ? xValidQ[1] : -1);
        end
    endtask

    task automatic test_random_ready();
        int d;
        for (int n = 0; n < 3; n++) begin
            d = $urandom_range(0, 4);
            run_layer(d, 1, 0);
            check_layer(d);
        end
    endtask

    task automatic test_abort();
        bit seen;
        ackDelay  = 0;
        readyMode = 0;
        @(posedge clk);
        #1;
        clear_logs();
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        seen = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #1;
            if (peCycQ.size() >= OUT_W + 1) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL abort_reach: pe strobes=%0d want %0d", peCycQ.size(), OUT_W + 1);
        end
        abort = 1;
        @(posedge clk);
        #1;
        abort = 0;
        checks++;
        if (ctrlVec !== '0) begin
            errors++;
            $display("[TB] FAIL abort_outputs: ctrl=%b want 0", ctrlVec);
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (doneCycQ.size() != 0 || rdCycQ.size() != OUT_W + 1) begin
            errors++;
            $display("[TB] FAIL abort_quiet: done=%0d rd=%0d want 0/%0d", doneCycQ.size(), rdCycQ.size(), OUT_W + 1);
        end
        run_layer(2, 0, 0);
        check_layer(2);
    endtask

    task automatic test_reset_mid();
        bit seen;
        ackDelay  = 0;
        readyMode = 0;
        @(posedge clk);
        #1;
        clear_logs();
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        seen = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #1;
            if (outValid && xCycQ.size() >= 3) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL rst_reach: out_valid=%b xfers=%0d want 1/3", outValid, xCycQ.size());
        end
        rst = 1;
        #1;
        checks++;
        if (ctrlVec !== '0 || addrVec !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: ctrl=%b addr=%h want 0", ctrlVec, addrVec);
        end
        @(posedge clk);
        #1;
        rst = 0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (ctrlVec !== '0) begin
            errors++;
            $display("[TB] FAIL post_reset_quiet: ctrl=%b want 0", ctrlVec);
        end
        run_layer(1, 0, 0);
        check_layer(1);
    endtask

    task automatic test_start_ignored();
        @(posedge clk);
        #1;
        start = 1;
        abort = 1;
        @(posedge clk);
        #1;
        start = 0;
        abort = 0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_abort_idle: busy=%b want 0", busy);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ctrlVec !== '0) begin
            errors++;
            $display("[TB] FAIL start_abort_quiet: ctrl=%b want 0", ctrlVec);
        end
        run_layer(1, 1, 1);
        check_layer(1);
    endtask

    initial begin
        test_reset();
        test_layer_basic();
        test_backpressure();
        test_random_ready();
        test_abort();
        test_reset_mid();
        test_start_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog");
    end

endmodule
